// File: rtl/upc_checkout_monitor.sv
// Checkout-station monitor: classifies accepted UPC scans, counts items and
// thefts, and latches a theft alarm that blocks scanning until cleared.
module upc_checkout_monitor #(
  parameter int unsigned UPC_W = 3,
  parameter int unsigned COUNT_W = 8,
  parameter logic [(2**UPC_W)-1:0] DISC_MASK = 8'b1110_1100,
  parameter logic [(2**UPC_W)-1:0] EXP_MASK = 8'b0010_0011
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [UPC_W-1:0]   upc,
  input  logic               marked,
  input  logic               scan_valid,
  output logic               scan_ready,
  input  logic               clear_alarm,
  input  logic               clear_counts,
  output logic               result_valid,
  output logic               discontinued,
  output logic               stolen,
  output logic               alarm,
  output logic [COUNT_W-1:0] item_count,
  output logic [COUNT_W-1:0] stolen_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESULT = 2'd1,
    ALARM  = 2'd2
  } state_e;

  localparam logic [COUNT_W-1:0] CMAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  state_e state_q, state_d;
  logic rv_q, rv_d;
  logic disc_q, disc_d;
  logic stol_q, stol_d;
  logic [COUNT_W-1:0] item_q, item_d;
  logic [COUNT_W-1:0] scnt_q, scnt_d;

  logic accept;
  logic disc_now;
  logic stol_now;
  logic [COUNT_W-1:0] item_base;
  logic [COUNT_W-1:0] scnt_base;

  // Ready depends only on state so there is no path from scan_valid.
  assign scan_ready = (state_q != ALARM);
  assign alarm      = (state_q == ALARM);
  assign accept     = scan_valid & scan_ready;
  assign disc_now   = DISC_MASK[upc];
  assign stol_now   = EXP_MASK[upc] & ~marked;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RESULT: begin
        if (accept) begin
          state_d = stol_now ? ALARM : RESULT;
        end else begin
          state_d = IDLE;
        end
      end
      ALARM: begin
        if (clear_alarm) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rv_d   = accept;
    disc_d = disc_q;
    stol_d = stol_q;
    if (accept) begin
      disc_d = disc_now;
      stol_d = stol_now;
    end
  end

  // A same-cycle clear lands first, then the accepted scan counts.
  always_comb begin
    item_base = clear_counts ? '0 : item_q;
    scnt_base = clear_counts ? '0 : scnt_q;
    item_d    = item_base;
    scnt_d    = scnt_base;
    if (accept && (item_base != CMAX)) begin
      item_d = item_base + ONE;
    end
    if (accept && stol_now && (scnt_base != CMAX)) begin
      scnt_d = scnt_base + ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rv_q    <= 1'b0;
      disc_q  <= 1'b0;
      stol_q  <= 1'b0;
      item_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rv_q    <= rv_d;
      disc_q  <= disc_d;
      stol_q  <= stol_d;
      item_q  <= item_d;
      scnt_q  <= scnt_d;
    end
  end

  assign result_valid = rv_q;
  assign discontinued = disc_q;
  assign stolen       = stol_q;
  assign item_count   = item_q;
  assign stolen_count = scnt_q;

endmodule

// File: tb/tb_upc_checkout_monitor.sv
// Directed bench for upc_checkout_monitor: default, narrow-counter and
// wide-code instances, with a scoreboard on the default instance.
module tb_upc_checkout_monitor;

  localparam logic [7:0] M_DISC = 8'b1110_1100;
  localparam logic [7:0] M_EXP  = 8'b0010_0011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] upc = '0;
  logic [3:0] upc4 = '0;
  logic marked = 1'b0;
  logic clear_alarm = 1'b0;
  logic clear_counts = 1'b0;
  logic sv0 = 1'b0;
  logic sv1 = 1'b0;
  logic sv2 = 1'b0;

  logic rdy0, rv0, disc0, stol0, alm0;
  logic [7:0] ic0, sc0;
  logic rdy1, rv1, disc1, stol1, alm1;
  logic [1:0] ic1, sc1;
  logic rdy2, rv2, disc2, stol2, alm2;
  logic [7:0] ic2, sc2;

  int tests = 0;
  int fails = 0;
  logic [1:0] sb[$];
  int exp_items = 0;
  int exp_stol = 0;
  int sat_items = 0;

  always #5 clk = ~clk;

  upc_checkout_monitor u0 (
    .clk(clk), .reset(reset), .upc(upc), .marked(marked),
    .scan_valid(sv0), .scan_ready(rdy0),
    .clear_alarm(clear_alarm), .clear_counts(clear_counts),
    .result_valid(rv0), .discontinued(disc0), .stolen(stol0),
    .alarm(alm0), .item_count(ic0), .stolen_count(sc0)
  );

  upc_checkout_monitor #(.COUNT_W(2)) u1 (
    .clk(clk), .reset(reset), .upc(upc), .marked(marked),
    .scan_valid(sv1), .scan_ready(rdy1),
    .clear_alarm(clear_alarm), .clear_counts(clear_counts),
    .result_valid(rv1), .discontinued(disc1), .stolen(stol1),
    .alarm(alm1), .item_count(ic1), .stolen_count(sc1)
  );

  upc_checkout_monitor #(
    .UPC_W(4), .COUNT_W(8),
    .DISC_MASK(16'h0000), .EXP_MASK(16'h1000)
  ) u2 (
    .clk(clk), .reset(reset), .upc(upc4), .marked(marked),
    .scan_valid(sv2), .scan_ready(rdy2),
    .clear_alarm(clear_alarm), .clear_counts(clear_counts),
    .result_valid(rv2), .discontinued(disc2), .stolen(stol2),
    .alarm(alm2), .item_count(ic2), .stolen_count(sc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and retire any scoreboard entry for u0.
  task automatic step();
    logic [1:0] e;
    @(posedge clk);
    #1;
    chk("rv_latency", {31'd0, rv0}, {31'd0, sb.size() > 0});
    if (rv0 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("disc", {31'd0, disc0}, {31'd0, e[1]});
      chk("stolen", {31'd0, stol0}, {31'd0, e[0]});
    end
  endtask

  // Present a u0 scan for one edge; push the expectation if it will be taken.
  task automatic scan0(input logic [2:0] code, input logic mk);
    logic st;
    upc = code;
    marked = mk;
    sv0 = 1'b1;
    if (rdy0) begin
      st = M_EXP[code] & ~mk;
      sb.push_back({M_DISC[code], st});
      exp_items++;
      if (st) exp_stol++;
    end
    step();
  endtask

  task automatic do_reset();
    sv0 = 1'b0;
    sv1 = 1'b0;
    sv2 = 1'b0;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    sb.delete();
    exp_items = 0;
    exp_stol = 0;
  endtask

  task automatic clr_alarm();
    clear_alarm = 1'b1;
    step();
    clear_alarm = 1'b0;
  endtask

  initial begin
    #12;
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, rdy0}, 32'd1);
    chk("rst_rv", {31'd0, rv0}, 32'd0);
    chk("rst_alarm", {31'd0, alm0}, 32'd0);
    chk("rst_items", {24'd0, ic0}, 32'd0);
    chk("rst_stol", {24'd0, sc0}, 32'd0);
    step();

    // Exhaustive classification with default masks.
    for (int mk = 0; mk < 2; mk++) begin
      for (int c = 0; c < 8; c++) begin
        scan0(3'(c), mk[0]);
        sv0 = 1'b0;
        chk("cls_items", {24'd0, ic0}, exp_items);
        chk("cls_stol", {24'd0, sc0}, exp_stol);
        chk("cls_alarm", {31'd0, alm0}, {31'd0, M_EXP[c] & ~mk[0]});
        if (alm0) begin
          chk("cls_ready_blk", {31'd0, rdy0}, 32'd0);
          clr_alarm();
          chk("cls_clr", {31'd0, alm0}, 32'd0);
          chk("cls_ready_back", {31'd0, rdy0}, 32'd1);
        end
      end
    end
    chk("cls_final_items", {24'd0, ic0}, 32'd16);
    chk("cls_final_stol", {24'd0, sc0}, 32'd3);

    // Back-to-back scans.
    do_reset();
    scan0(3'd2, 1'b1);
    chk("b2b_ic1", {24'd0, ic0}, 32'd1);
    scan0(3'd3, 1'b1);
    chk("b2b_ic2", {24'd0, ic0}, 32'd2);
    chk("b2b_rv2", {31'd0, rv0}, 32'd1);
    scan0(3'd6, 1'b1);
    chk("b2b_ic3", {24'd0, ic0}, 32'd3);
    chk("b2b_rv3", {31'd0, rv0}, 32'd1);
    chk("b2b_alarm", {31'd0, alm0}, 32'd0);
    sv0 = 1'b0;
    step();

    // Alarm blocks scans until cleared.
    do_reset();
    scan0(3'd0, 1'b0);
    chk("blk_alarm", {31'd0, alm0}, 32'd1);
    chk("blk_ready", {31'd0, rdy0}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      scan0(3'd2, 1'b1);
    end
    chk("blk_items", {24'd0, ic0}, 32'd1);
    clear_alarm = 1'b1;
    scan0(3'd2, 1'b1);
    clear_alarm = 1'b0;
    chk("blk_ready_back", {31'd0, rdy0}, 32'd1);
    chk("blk_alarm_clr", {31'd0, alm0}, 32'd0);
    scan0(3'd2, 1'b1);
    sv0 = 1'b0;
    chk("blk_items2", {24'd0, ic0}, 32'd2);

    // Asynchronous reset from ALARM with non-zero counts.
    scan0(3'd1, 1'b0);
    sv0 = 1'b0;
    chk("pre_rst_alarm", {31'd0, alm0}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_alarm", {31'd0, alm0}, 32'd0);
    chk("arst_ready", {31'd0, rdy0}, 32'd1);
    chk("arst_items", {24'd0, ic0}, 32'd0);
    chk("arst_stol", {24'd0, sc0}, 32'd0);
    chk("arst_disc", {31'd0, disc0}, 32'd0);
    chk("arst_stolen", {31'd0, stol0}, 32'd0);
    reset = 1'b0;
    sb.delete();
    exp_items = 0;
    exp_stol = 0;
    scan0(3'd5, 1'b1);
    sv0 = 1'b0;
    chk("post_rst_accept", {24'd0, ic0}, 32'd1);

    // Saturation with a 2-bit counter, then clear plus scan together.
    do_reset();
    upc = 3'd3;
    marked = 1'b0;
    sv1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      sat_items = (sat_items == 3) ? 3 : sat_items + 1;
      chk("sat_items", {30'd0, ic1}, sat_items);
    end
    chk("sat_stol", {30'd0, sc1}, 32'd0);
    upc = 3'd1;
    clear_counts = 1'b1;
    @(posedge clk);
    #1;
    clear_counts = 1'b0;
    sv1 = 1'b0;
    chk("clr_items", {30'd0, ic1}, 32'd1);
    chk("clr_stol", {30'd0, sc1}, 32'd1);
    chk("clr_alarm", {31'd0, alm1}, 32'd1);
    clear_alarm = 1'b1;
    @(posedge clk);
    #1;
    clear_alarm = 1'b0;

    // Wide code space with code 12 expensive.
    do_reset();
    upc4 = 4'd12;
    marked = 1'b0;
    sv2 = 1'b1;
    @(posedge clk);
    #1;
    sv2 = 1'b0;
    chk("w_alarm", {31'd0, alm2}, 32'd1);
    chk("w_stolen", {31'd0, stol2}, 32'd1);
    clear_alarm = 1'b1;
    @(posedge clk);
    #1;
    clear_alarm = 1'b0;
    marked = 1'b1;
    sv2 = 1'b1;
    @(posedge clk);
    #1;
    sv2 = 1'b0;
    chk("w_alarm_marked", {31'd0, alm2}, 32'd0);
    chk("w_stolen_marked", {31'd0, stol2}, 32'd0);
    chk("w_items", {24'd0, ic2}, 32'd2);

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/upc_checkout_monitor.md
# upc_checkout_monitor

Sequential, parametrised checkout-station monitor for the DE1-SoC store-checkout labs. Accepts UPC scans via a valid/ready handshake and classifies each item from per-code mask parameters as discontinued or stolen (expensive and unmarked). Keeps saturating item and theft counters, and latches a theft alarm that blocks further scans until cleared. Sits between debounced switch/KEY inputs and the LEDR/HEX display logic in the top level.

## Interface

Parameters:
- UPC_W, default 3: UPC code width; the code space is 2**UPC_W.
- COUNT_W, default 8: width of each counter.
- DISC_MASK, default 8'b1110_1100 (width 2**UPC_W): bit k=1 means code k is discontinued.
- EXP_MASK, default 8'b0010_0011 (width 2**UPC_W): bit k=1 means code k is expensive.

Ports (name, direction, width, meaning):
- clk, input, 1: single clock. All state changes on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- upc, input, UPC_W: UPC code being scanned.
- marked, input, 1: item carries a paid/security mark.
- scan_valid, input, 1: a scan is presented.
- scan_ready, output, 1: the block can accept a scan.
- clear_alarm, input, 1: acknowledges and clears a latched alarm.
- clear_counts, input, 1: synchronous clear of both counters.
- result_valid, output, 1: one-cycle pulse; discontinued and stolen are meaningful.
- discontinued, output, 1: DISC_MASK[upc] of the accepted scan.
- stolen, output, 1: EXP_MASK[upc] & ~marked of the accepted scan.
- alarm, output, 1: latched theft alarm.
- item_count, output, COUNT_W: number of accepted scans, saturating.
- stolen_count, output, COUNT_W: number of stolen classifications, saturating.

## Operation

- A scan is accepted in any cycle where scan_valid and scan_ready are both high. upc and marked are sampled in that same cycle.
- Classification:
  - discontinued = DISC_MASK[upc].
  - stolen = EXP_MASK[upc] & ~marked.
  - The discontinued flag does not depend on marked.
- The FSM has three states: IDLE, RESULT and ALARM.
  - IDLE: scan_ready=1. An accepted scan with stolen=0 goes to RESULT. An accepted scan with stolen=1 goes to ALARM. No scan stays in IDLE.
  - RESULT: result_valid=1 for exactly this cycle, and scan_ready=1. An accepted scan follows the same rules as in IDLE, so back-to-back scans give one result per cycle. No scan returns to IDLE.
  - ALARM: scan_ready=0 and alarm=1. result_valid=1 only in the first ALARM cycle. clear_alarm=1 goes to IDLE on the next edge. Otherwise the FSM stays in ALARM.
- discontinued and stolen are registered and hold their last value until the next accepted scan.
- Counters:
  - item_count increments by 1 per accepted scan.
  - stolen_count increments by 1 per accepted scan with stolen=1.
  - Both saturate at 2**COUNT_W-1 and never wrap.
- clear_counts zeroes both counters. If a scan is accepted in the same cycle, the clear is applied first and then that scan's increments, so the result is item_count=1 and stolen_count equal to the scan's stolen value.
- clear_alarm outside the ALARM state has no effect.
- scan_valid while scan_ready=0 is ignored and not queued.
- upc and marked values are don't-care when no scan is accepted.

## Timing

- Reset (asynchronous, immediate, independent of clk):
  - FSM goes to IDLE.
  - scan_ready=1.
  - result_valid, discontinued, stolen and alarm are 0.
  - item_count and stolen_count are 0.
- Reset asserted mid-operation, including in ALARM, discards all state. The first edge after reset deasserts can accept a scan.
- Latency is 1 cycle. For a scan accepted at edge N:
  - result_valid, discontinued, stolen and the counters update at N+1.
  - alarm rises at N+1 if the scan was stolen.
- scan_ready is a function of the FSM state only, with no combinational path from scan_valid.
- alarm falls, and scan_ready rises, at the edge after the cycle in which clear_alarm is sampled high.
- Throughput is 1 scan/cycle while no theft is detected. After a theft, the minimum gap before the next accepted scan is 2 cycles: one alarm cycle plus the clear cycle.

## Test plan

- **Reset values:** assert reset mid-cycle with counts non-zero and alarm=1 -> all outputs go to 0 immediately, scan_ready=1, item_count=0.
- **Exhaustive classify with defaults:** scan every code 0..7 with marked=0 and with marked=1, clearing the alarm each time it is raised.
  - Required discontinued set: codes {2,3,5,6,7}.
  - Required stolen set: codes {0,1,5}, and only when marked=0.
  - Final counts: item_count=16, stolen_count=3.
- **Back-to-back scans:** codes 2,3,6 with marked=1 on consecutive cycles -> result_valid high for 3 consecutive cycles, item_count goes 1,2,3, alarm stays 0.
- **Alarm blocking:** scan code 0 with marked=0 -> alarm=1 and scan_ready=0 at N+1. Hold scan_valid with code 2 for 5 cycles -> item_count stays 1. Pulse clear_alarm -> scan_ready=1 next cycle, then code 2 is accepted.
- **Saturation and clear:** with COUNT_W=2, accept 6 unmarked scans of code 3 -> item_count stays at 3. Then apply clear_counts together with an accepted scan of code 1 (marked=0) -> item_count=1, stolen_count=1.
- **Non-default parameters:** UPC_W=4 with an alternate EXP_MASK that includes code 12 -> scanning code 12 with marked=0 raises alarm, and scanning code 12 with marked=1 does not.
